pipe_ctrl: RTL and testbench

//  Valid/allow-in sequencer for the five-stage pipeline (IF, ID, EXE, MEM, WB).

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_stage_valid.sv | 37 +++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage names, reset PC, inter-stage bus widths
// and the allow-in helper used by the controller.
package pipe_pkg;

  typedef enum logic [2:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EXE = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stage_e;

  localparam logic [31:0] STARTADDR   = 32'h00000034;
  localparam int          IF_ID_BUS_W = 64;
  localparam int          JBR_BUS_W   = 33;
  localparam int          EXC_BUS_W   = 33;

  // A stage accepts a new instruction when empty or when its occupant can move on.
  function automatic logic allow_in(input logic valid, input logic over, input logic next_ai);
    return (~valid) | (over & next_ai);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller (master) and the stage
// modules (slave): stage-done inputs, valids, latch enables and counters.
interface pipe_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              IF_over, ID_over, EXE_over, MEM_over, WB_over;
  logic              exc_valid;
  logic              IF_valid, next_fetch;
  logic              ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic              IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
  logic [PERF_W-1:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

  modport master (
    input  IF_over, ID_over, EXE_over, MEM_over, WB_over, exc_valid,
    output IF_valid, next_fetch, ID_valid, EXE_valid, MEM_valid, WB_valid,
    output IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
    output cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    output IF_over, ID_over, EXE_over, MEM_over, WB_over, exc_valid,
    input  IF_valid, next_fetch, ID_valid, EXE_valid, MEM_valid, WB_valid,
    input  IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
    input  cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_valid.sv
// Valid bit of one pipeline stage: loads the feeding stage's latch enable when
// the stage allows in, holds otherwise, and clears on flush.
module pipe_stage_valid (
  input  logic clk,
  input  logic resetn,
  input  logic allow_in,
  input  logic in_en,
  input  logic flush,
  output logic valid
);

  logic valid_d, valid_q;

  // next valid: flush beats advance, advance beats hold
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (allow_in) begin
      valid_d = in_en;
    end else begin
      valid_d = valid_q;
    end
  end

  // valid register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Valid/allow-in sequencer for the IF-ID-EXE-MEM-WB pipeline with exception flush.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int START_DELAY = 1,
  parameter int PERF_W      = 32
) (
  input  logic            clk,
  input  logic            resetn,
  pipe_ctrl_if.master     pif
);

  localparam int SW = $clog2(START_DELAY + 1) + 1;

  logic [SW-1:0] start_cnt_d, start_cnt_q;
  logic          if_valid_d, if_valid_q;
  logic          id_valid_s, exe_valid_s, mem_valid_s, wb_valid_s;
  logic          id_ai_s, exe_ai_s, mem_ai_s, wb_ai_s;
  logic          if_id_en_s, id_exe_en_s, exe_mem_en_s, mem_wb_en_s;
  logic          exc_s;

  assign exc_s = pif.exc_valid;

  // fetch start-up delay after reset release
  always_comb begin
    start_cnt_d = start_cnt_q;
    if_valid_d  = if_valid_q;
    if (start_cnt_q != {SW{1'b0}}) begin
      start_cnt_d = start_cnt_q - SW'(1);
      if (start_cnt_q == SW'(1)) begin
        if_valid_d = 1'b1;
      end else begin
        if_valid_d = if_valid_q;
      end
    end else begin
      start_cnt_d = start_cnt_q;
    end
  end

  // fetch-enable and start counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_cnt_q <= SW'(START_DELAY);
      if_valid_q  <= 1'b0;
    end else begin
      start_cnt_q <= start_cnt_d;
      if_valid_q  <= if_valid_d;
    end
  end

  // allow-in chain from WB backwards; a flush suppresses every latch except MEM->WB
  always_comb begin
    wb_ai_s      = allow_in(wb_valid_s,  pif.WB_over,  1'b1);
    mem_ai_s     = allow_in(mem_valid_s, pif.MEM_over, wb_ai_s);
    exe_ai_s     = allow_in(exe_valid_s, pif.EXE_over, mem_ai_s);
    id_ai_s      = allow_in(id_valid_s,  pif.ID_over,  exe_ai_s);
    if_id_en_s   = if_valid_q  & pif.IF_over  & id_ai_s  & ~exc_s;
    id_exe_en_s  = id_valid_s  & pif.ID_over  & exe_ai_s & ~exc_s;
    exe_mem_en_s = exe_valid_s & pif.EXE_over & mem_ai_s & ~exc_s;
    mem_wb_en_s  = mem_valid_s & pif.MEM_over & wb_ai_s;
  end

  pipe_stage_valid u_id_valid (
    .clk(clk), .resetn(resetn), .allow_in(id_ai_s), .in_en(if_id_en_s),
    .flush(exc_s), .valid(id_valid_s)
  );

  pipe_stage_valid u_exe_valid (
    .clk(clk), .resetn(resetn), .allow_in(exe_ai_s), .in_en(id_exe_en_s),
    .flush(exc_s), .valid(exe_valid_s)
  );

  pipe_stage_valid u_mem_valid (
    .clk(clk), .resetn(resetn), .allow_in(mem_ai_s), .in_en(exe_mem_en_s),
    .flush(exc_s), .valid(mem_valid_s)
  );

  // the instruction moving into WB during a flush is kept so it still retires
  pipe_stage_valid u_wb_valid (
    .clk(clk), .resetn(resetn), .allow_in(wb_ai_s), .in_en(mem_wb_en_s),
    .flush(exc_s & ~mem_wb_en_s), .valid(wb_valid_s)
  );

  assign pif.IF_valid   = if_valid_q;
  assign pif.next_fetch = if_id_en_s | exc_s;
  assign pif.ID_valid   = id_valid_s;
  assign pif.EXE_valid  = exe_valid_s;
  assign pif.MEM_valid  = mem_valid_s;
  assign pif.WB_valid   = wb_valid_s;
  assign pif.IF_ID_en   = if_id_en_s;
  assign pif.ID_EXE_en  = id_exe_en_s;
  assign pif.EXE_MEM_en = exe_mem_en_s;
  assign pif.MEM_WB_en  = mem_wb_en_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] cycle_cnt_d, cycle_cnt_q, retire_cnt_d, retire_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // event counters, wrapping at their width
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q  + PERF_W'(if_valid_q);
    retire_cnt_d = retire_cnt_q + PERF_W'(wb_valid_s & pif.WB_over);
    stall_cnt_d  = stall_cnt_q  + PERF_W'(if_valid_q & pif.IF_over & ~id_ai_s);
    flush_cnt_d  = flush_cnt_q  + PERF_W'(exc_s);
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_cnt_q  <= {PERF_W{1'b0}};
      retire_cnt_q <= {PERF_W{1'b0}};
      stall_cnt_q  <= {PERF_W{1'b0}};
      flush_cnt_q  <= {PERF_W{1'b0}};
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign pif.cycle_cnt  = cycle_cnt_q;
  assign pif.retire_cnt = retire_cnt_q;
  assign pif.stall_cnt  = stall_cnt_q;
  assign pif.flush_cnt  = flush_cnt_q;
`else
  assign pif.cycle_cnt  = {PERF_W{1'b0}};
  assign pif.retire_cnt = {PERF_W{1'b0}};
  assign pif.stall_cnt  = {PERF_W{1'b0}};
  assign pif.flush_cnt  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: slot-level pipeline model checked every cycle plus
// directed scenarios; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  localparam int PERF_W = 4;
  localparam int CMASK  = (1 << PERF_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipe_ctrl_if #(.PERF_W(PERF_W)) pif ();

  pipe_ctrl #(.START_DELAY(1), .PERF_W(PERF_W)) dut (
    .clk(clk), .resetn(resetn), .pif(pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_over(input logic [4:0] v);
    {pif.IF_over, pif.ID_over, pif.EXE_over, pif.MEM_over, pif.WB_over} = v;
  endtask

  // Model: occ[] holds the id of the instruction in ID/EXE/MEM/WB (0 = empty).
  initial begin : model_and_compare
    int occ[4];
    int nocc[4];
    bit ov[4];
    bit ready[4];
    bit take[4];
    bit leave[4];
    bit live, m_ifv, fetch, exc;
    int m_start, cyc, ret, stl, fls, next_id;
    live = 1'b0; m_ifv = 1'b0; m_start = 1;
    cyc = 0; ret = 0; stl = 0; fls = 0; next_id = 1;
    for (int s = 0; s < 4; s++) occ[s] = 0;
    forever begin
      @(negedge clk);
      exc   = pif.exc_valid;
      ov[0] = pif.ID_over; ov[1] = pif.EXE_over; ov[2] = pif.MEM_over; ov[3] = pif.WB_over;
      for (int s = 3; s >= 0; s--) begin
        bit down_ok;
        down_ok  = (s == 3) ? 1'b1 : take[s+1];
        ready[s] = (occ[s] != 0) && ov[s] && down_ok;
        take[s]  = (occ[s] == 0) || ready[s];
        leave[s] = ready[s] && (s >= 2 || !exc);
      end
      fetch = m_ifv && pif.IF_over && take[0] && !exc;
      if (live) begin
        chk("IF_valid",   pif.IF_valid,   m_ifv);
        chk("ID_valid",   pif.ID_valid,   occ[0] != 0);
        chk("EXE_valid",  pif.EXE_valid,  occ[1] != 0);
        chk("MEM_valid",  pif.MEM_valid,  occ[2] != 0);
        chk("WB_valid",   pif.WB_valid,   occ[3] != 0);
        chk("IF_ID_en",   pif.IF_ID_en,   fetch);
        chk("ID_EXE_en",  pif.ID_EXE_en,  leave[0]);
        chk("EXE_MEM_en", pif.EXE_MEM_en, leave[1]);
        chk("MEM_WB_en",  pif.MEM_WB_en,  leave[2]);
        chk("next_fetch", pif.next_fetch, fetch || exc);
        chk("cycle_cnt",  pif.cycle_cnt,  PERF ? cyc : 0);
        chk("retire_cnt", pif.retire_cnt, PERF ? ret : 0);
        chk("stall_cnt",  pif.stall_cnt,  PERF ? stl : 0);
        chk("flush_cnt",  pif.flush_cnt,  PERF ? fls : 0);
      end
      if (!resetn) begin
        for (int s = 0; s < 4; s++) occ[s] = 0;
        m_ifv = 1'b0; m_start = 1;
        cyc = 0; ret = 0; stl = 0; fls = 0;
        live = 1'b1;
      end else if (live) begin
        cyc = (cyc + int'(m_ifv)) & CMASK;
        ret = (ret + int'(ready[3])) & CMASK;
        stl = (stl + int'(m_ifv && pif.IF_over && !take[0])) & CMASK;
        fls = (fls + int'(exc)) & CMASK;
        nocc[3] = leave[2] ? occ[2] : ((ready[3] || exc) ? 0 : occ[3]);
        for (int s = 2; s >= 1; s--)
          nocc[s] = exc ? 0 : (leave[s-1] ? occ[s-1] : (leave[s] ? 0 : occ[s]));
        nocc[0] = exc ? 0 : (fetch ? next_id : (leave[0] ? 0 : occ[0]));
        if (fetch) next_id++;
        for (int s = 0; s < 4; s++) occ[s] = nocc[s];
        if (m_start > 0) begin
          m_start--;
          if (m_start == 0) m_ifv = 1'b1;
        end
      end
    end
  end

  logic [4:0] vec [20] = '{5'b11111, 5'b11111, 5'b11110, 5'b11110, 5'b11111,
                           5'b10111, 5'b11011, 5'b11101, 5'b01111, 5'b11111,
                           5'b11010, 5'b11111, 5'b11100, 5'b11111, 5'b10101,
                           5'b11111, 5'b11111, 5'b01110, 5'b11111, 5'b11111};

  initial begin : stimulus
    resetn = 1'b0;
    set_over(5'b11111);
    pif.exc_valid = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    // cycle 0: out of reset, nothing live yet
    chk("rst_IF_valid", pif.IF_valid, 1'b0);
    chk("rst_ID_valid", pif.ID_valid, 1'b0);
    chk("rst_next_fetch", pif.next_fetch, 1'b0);
    chk("rst_IF_ID_en", pif.IF_ID_en, 1'b0);
    tick();  // cycle 1
    chk("c1_IF_valid", pif.IF_valid, 1'b1);
    chk("c1_IF_ID_en", pif.IF_ID_en, 1'b1);
    chk("c1_ID_valid", pif.ID_valid, 1'b0);
    repeat (4) tick();  // cycle 5
    chk("c5_WB_valid", pif.WB_valid, 1'b1);
    chk("c5_next_fetch", pif.next_fetch, 1'b1);
    tick();  // cycle 6
    chk("c6_retire_cnt", pif.retire_cnt, PERF ? 4'd1 : 4'd0);
    chk("c6_cycle_cnt", pif.cycle_cnt, PERF ? 4'd5 : 4'd0);
    // EXE multi-cycle stall for three cycles
    pif.EXE_over = 1'b0; #1;
    chk("stall_ID_EXE_en", pif.ID_EXE_en, 1'b0);
    chk("stall_IF_ID_en", pif.IF_ID_en, 1'b0);
    chk("stall_next_fetch", pif.next_fetch, 1'b0);
    chk("stall_MEM_WB_en", pif.MEM_WB_en, 1'b1);
    tick(); tick();  // cycle 8
    chk("stall_ID_hold", pif.ID_valid, 1'b1);
    chk("stall_MEM_drain", pif.MEM_valid, 1'b0);
    tick();  // cycle 9
    pif.EXE_over = 1'b1; #1;
    chk("stall_cnt_3", pif.stall_cnt, PERF ? 4'd3 : 4'd0);
    chk("resume_ID_EXE_en", pif.ID_EXE_en, 1'b1);
    repeat (3) tick();  // cycle 12, pipeline full
    pif.exc_valid = 1'b1; #1;
    chk("exc_next_fetch", pif.next_fetch, 1'b1);
    chk("exc_IF_ID_en", pif.IF_ID_en, 1'b0);
    chk("exc_EXE_MEM_en", pif.EXE_MEM_en, 1'b0);
    chk("exc_MEM_WB_en", pif.MEM_WB_en, 1'b1);
    tick();  // cycle 13
    pif.exc_valid = 1'b0; #1;
    chk("flush_ID", pif.ID_valid, 1'b0);
    chk("flush_EXE", pif.EXE_valid, 1'b0);
    chk("flush_MEM", pif.MEM_valid, 1'b0);
    chk("flush_WB_kept", pif.WB_valid, 1'b1);
    chk("flush_MEM_WB_en", pif.MEM_WB_en, 1'b0);
    chk("flush_cnt_1", pif.flush_cnt, PERF ? 4'd1 : 4'd0);
    repeat (2) tick();  // cycle 15
    // exception coincident with a decode stall
    pif.ID_over = 1'b0; pif.exc_valid = 1'b1; #1;
    chk("excstall_IF_ID_en", pif.IF_ID_en, 1'b0);
    chk("excstall_next_fetch", pif.next_fetch, 1'b1);
    chk("excstall_ID_before", pif.ID_valid, 1'b1);
    tick();  // cycle 16
    pif.ID_over = 1'b1; pif.exc_valid = 1'b0; #1;
    chk("excstall_ID_cleared", pif.ID_valid, 1'b0);
    chk("excstall_EXE_cleared", pif.EXE_valid, 1'b0);
    repeat (4) tick();  // cycle 20
    resetn = 1'b0;
    tick();  // cycle 21
    chk("mrst_IF_valid", pif.IF_valid, 1'b0);
    chk("mrst_WB_valid", pif.WB_valid, 1'b0);
    chk("mrst_MEM_valid", pif.MEM_valid, 1'b0);
    chk("mrst_retire_cnt", pif.retire_cnt, 4'd0);
    chk("mrst_cycle_cnt", pif.cycle_cnt, 4'd0);
    resetn = 1'b1;
    tick();  // cycle 22
    chk("mrst_IF_back", pif.IF_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      set_over(vec[i]);
      tick();
    end
    chk("cycle_cnt_wrap", pif.cycle_cnt, PERF ? 4'd4 : 4'd0);
    set_over(5'b11111);
    repeat (6) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
